// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit ALU between two requesters.
// Sequence per operation: IDLE -> LOAD -> EXEC (EXEC_CYCLES) -> DONE, illegal opcodes skip to DONE.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [6:0] op0,
    input  logic [7:0] fi0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [6:0] op1,
    input  logic [7:0] fi1,
    output logic       ack0,
    output logic       ack1,
    output logic       err,
    output logic [7:0] res,
    output logic [7:0] flo,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_fi,
    output logic [6:0] alu_op,
    output logic       alu_wa,
    output logic       alu_wb,
    output logic       alu_oe,
    input  logic [7:0] alu_d,
    input  logic [7:0] alu_fo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] state;
    logic       prio;
    logic       gnt;
    logic       err_q;
    logic [6:0] op_q;
    logic [7:0] fi_q;
    logic [3:0] cnt;

    logic       any_req;
    logic       pick;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [6:0] sel_op;
    logic [7:0] sel_fi;
    logic       sel_legal;

    // With both requests high prio decides; otherwise whichever is asserting wins.
    always_comb begin
        any_req   = req0 | req1;
        pick      = (req0 && req1) ? prio : req1;
        sel_a     = pick ? a1  : a0;
        sel_b     = pick ? b1  : b0;
        sel_op    = pick ? op1 : op0;
        sel_fi    = pick ? fi1 : fi0;
        sel_legal = (sel_op != '0) && ((sel_op & (sel_op - 7'd1)) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            prio   <= 1'b0;
            gnt    <= 1'b0;
            err_q  <= 1'b0;
            op_q   <= '0;
            fi_q   <= '0;
            cnt    <= '0;
            res    <= '0;
            flo    <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_fi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt  <= pick;
                        prio <= ~pick;
                        op_q <= sel_op;
                        fi_q <= sel_fi;
                        if (sel_legal) begin
                            alu_a <= sel_a;
                            alu_b <= sel_b;
                            err_q <= 1'b0;
                            state <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    alu_fi <= fi_q;
                    cnt    <= 4'(EXEC_CYCLES - 1);
                    state  <= EXEC;
                end
                EXEC: begin
                    if (cnt == '0) begin
                        res   <= alu_d;
                        flo   <= alu_fo;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_wa = (state == LOAD);
    assign alu_wb = (state == LOAD);
    assign alu_oe = (state == EXEC);
    assign alu_op = alu_oe ? op_q : '0;
    assign ack0   = (state == DONE) && !gnt;
    assign ack1   = (state == DONE) && gnt;
    assign err    = (state == DONE) && err_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYCLES 1 and 4) on shared stimulus,
// checked each cycle against an operation-level reference model plus directed sequences.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, fi0 = '0, a1 = '0, b1 = '0, fi1 = '0;
    logic [6:0] op0 = '0, op1 = '0;
    logic [7:0] alu_d = '0, alu_fo = '0;

    logic       ack0_1, ack1_1, err_1, busy_1, wa_1, wb_1, oe_1;
    logic [7:0] res_1, flo_1, aa_1, ab_1, afi_1;
    logic [6:0] aop_1;
    logic       ack0_4, ack1_4, err_4, busy_4, wa_4, wb_4, oe_4;
    logic [7:0] res_4, flo_4, aa_4, ab_4, afi_4;
    logic [6:0] aop_4;

    always #5 clk = ~clk;

    alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .fi0(fi0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .fi1(fi1),
        .ack0(ack0_1), .ack1(ack1_1), .err(err_1), .res(res_1), .flo(flo_1), .busy(busy_1),
        .alu_a(aa_1), .alu_b(ab_1), .alu_fi(afi_1), .alu_op(aop_1),
        .alu_wa(wa_1), .alu_wb(wb_1), .alu_oe(oe_1), .alu_d(alu_d), .alu_fo(alu_fo)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .fi0(fi0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .fi1(fi1),
        .ack0(ack0_4), .ack1(ack1_4), .err(err_4), .res(res_4), .flo(flo_4), .busy(busy_4),
        .alu_a(aa_4), .alu_b(ab_4), .alu_fi(afi_4), .alu_op(aop_4),
        .alu_wa(wa_4), .alu_wb(wb_4), .alu_oe(oe_4), .alu_d(alu_d), .alu_fo(alu_fo)
    );

    typedef struct packed {
        logic       ack0, ack1, err;
        logic [7:0] res, flo;
        logic       busy;
        logic [7:0] a, b, fi;
        logic [6:0] op;
        logic       wa, wb, oe;
    } outs_t;

    typedef struct {
        logic       r0, r1;
        logic [6:0] o0, o1;
        logic       wa, wb, oe;
        logic [6:0] op;
        logic       k0, k1, er;
        logic [7:0] res;
        logic       bsy;
    } vec_t;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    function automatic outs_t dut_outs(input int i);
        outs_t o;
        if (i == 0) o = '{ack0_1, ack1_1, err_1, res_1, flo_1, busy_1, aa_1, ab_1, afi_1, aop_1, wa_1, wb_1, oe_1};
        else        o = '{ack0_4, ack1_4, err_4, res_4, flo_4, busy_4, aa_4, ab_4, afi_4, aop_4, wa_4, wb_4, oe_4};
        return o;
    endfunction

    // Reference model: one in-flight operation, phase t counted in cycles from the grant.
    bit          m_busy[2], m_gnt[2], m_legal[2], m_prio[2];
    int unsigned m_t[2];
    logic [6:0]  m_op[2];
    logic [7:0]  m_res[2], m_flo[2], m_a[2], m_b[2], m_fi[2], m_lfi[2];

    function automatic int unsigned ex(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_gnt[i] = 0; m_legal[i] = 0; m_prio[i] = 0; m_t[i] = 0;
            m_op[i] = '0; m_res[i] = '0; m_flo[i] = '0; m_a[i] = '0; m_b[i] = '0;
            m_fi[i] = '0; m_lfi[i] = '0;
        end
    endtask

    task automatic m_step(input int i);
        int g;
        if (!m_busy[i]) begin
            g = -1;
            if (req0 && req1) g = m_prio[i] ? 1 : 0;
            else if (req0) g = 0;
            else if (req1) g = 1;
            if (g >= 0) begin
                m_busy[i]  = 1;
                m_t[i]     = 0;
                m_gnt[i]   = (g == 1);
                m_prio[i]  = (g == 0);
                m_op[i]    = (g == 1) ? op1 : op0;
                m_lfi[i]   = (g == 1) ? fi1 : fi0;
                m_legal[i] = $onehot(m_op[i]);
                if (m_legal[i]) begin
                    m_a[i] = (g == 1) ? a1 : a0;
                    m_b[i] = (g == 1) ? b1 : b0;
                end
            end
        end else begin
            if (m_legal[i] && m_t[i] == 0) m_fi[i] = m_lfi[i];
            if (m_legal[i] && m_t[i] == ex(i)) begin
                m_res[i] = alu_d;
                m_flo[i] = alu_fo;
            end
            if (m_t[i] == (m_legal[i] ? ex(i) + 1 : 0)) m_busy[i] = 0;
            else m_t[i]++;
        end
    endtask

    function automatic outs_t m_exp(input int i);
        outs_t o;
        o = '0;
        o.res = m_res[i]; o.flo = m_flo[i]; o.a = m_a[i]; o.b = m_b[i]; o.fi = m_fi[i];
        if (m_busy[i]) begin
            o.busy = 1'b1;
            if (m_legal[i]) begin
                o.wa = (m_t[i] == 0);
                o.wb = (m_t[i] == 0);
                o.oe = (m_t[i] >= 1) && (m_t[i] <= ex(i));
                o.op = o.oe ? m_op[i] : '0;
                if (m_t[i] == ex(i) + 1) begin
                    o.ack0 = !m_gnt[i];
                    o.ack1 = m_gnt[i];
                end
            end else begin
                o.ack0 = !m_gnt[i];
                o.ack1 = m_gnt[i];
                o.err  = 1'b1;
            end
        end
        return o;
    endfunction

    // Inputs are driven at the falling edge; model steps, then outputs are compared one cycle on.
    task automatic advance();
        m_step(0);
        m_step(1);
        @(negedge clk);
        chk("model_e1", 64'(dut_outs(0)), 64'(m_exp(0)));
        chk("model_e4", 64'(dut_outs(1)), 64'(m_exp(1)));
    endtask

    task automatic wait_idle();
        int unsigned n;
        req0 = 0; req1 = 0;
        n = 0;
        while ((busy_1 || busy_4) && n < 30) begin
            advance();
            n++;
        end
        chk("idle_timeout", 64'(busy_1 | busy_4), 64'(0));
    endtask

    vec_t        vecs[6];
    int unsigned last_ack, cyc, oe_n, k;
    logic [7:0]  dv, cap;
    bit          who, got;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 7'h01, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1};
        vecs[1] = '{1'b0, 1'b0, 7'h01, 7'h00, 1'b0, 1'b0, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1};
        vecs[2] = '{1'b0, 1'b0, 7'h01, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 8'd101, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 7'h01, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 8'd101, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 7'h01, 7'h03, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 8'd101, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 7'h01, 7'h03, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 8'd101, 1'b0};

        #1 rst = 0;
        #1;
        chk("reset_e1", 64'(dut_outs(0)), 64'(0));
        chk("reset_e4", 64'(dut_outs(1)), 64'(0));
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1;

        // Single add, dropped request, then an illegal two-bit opcode; ALU stub returns 100+1.
        a0 = 8'd100; b0 = 8'd1; fi0 = 8'h00; a1 = 8'd7; b1 = 8'd9; fi1 = 8'h33;
        alu_d = 8'd101; alu_fo = 8'h5a;
        for (int i = 0; i < 6; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; op0 = vecs[i].o0; op1 = vecs[i].o1;
            advance();
            chk($sformatf("vec%0d", i),
                64'({wa_1, wb_1, oe_1, aop_1, ack0_1, ack1_1, err_1, res_1, busy_1}),
                64'({vecs[i].wa, vecs[i].wb, vecs[i].oe, vecs[i].op, vecs[i].k0, vecs[i].k1,
                     vecs[i].er, vecs[i].res, vecs[i].bsy}));
        end
        wait_idle();

        // Both requesting continuously: grants alternate 0,1,0,1, one op every 4 cycles.
        req0 = 1; req1 = 1; op0 = 7'h02; op1 = 7'h08; a0 = 8'd11; a1 = 8'd22;
        cyc = 0; last_ack = 0;
        for (int n = 0; n < 4; n++) begin
            got = 0;
            for (int w = 0; w < 20 && !got; w++) begin
                alu_d = 8'($urandom); alu_fo = 8'($urandom);
                advance();
                cyc++;
                if (ack0_1 || ack1_1) got = 1;
            end
            chk($sformatf("alt_ack%0d_seen", n), 64'(got), 64'(1));
            who = ack1_1;
            chk($sformatf("alt_order%0d", n), 64'(who), 64'(n % 2));
            if (n == 0) chk("alt_first_latency", 64'(cyc), 64'(3));
            else chk($sformatf("alt_spacing%0d", n), 64'(cyc - last_ack), 64'(4));
            last_ack = cyc;
        end
        wait_idle();

        // EXEC_CYCLES=4: oe for exactly 4 cycles, capture takes the value from the 4th.
        req0 = 1; op0 = 7'h40; a0 = 8'd5; b0 = 8'd6; fi0 = 8'h81;
        advance();
        req0 = 0;
        oe_n = 0; cap = '0; got = 0;
        for (k = 0; k < 30 && !got; k++) begin
            dv = 8'hA0 + 8'(k);
            if (oe_4) begin
                oe_n++;
                cap = dv;
            end
            alu_d = dv; alu_fo = ~dv;
            advance();
            if (ack0_4) got = 1;
        end
        chk("e4_ack_seen", 64'(got), 64'(1));
        chk("e4_oe_cycles", 64'(oe_n), 64'(4));
        chk("e4_res_capture", 64'({res_4, flo_4}), 64'({cap, ~cap}));
        wait_idle();

        // Asynchronous reset in the middle of EXEC, then restart with req0 still held.
        req0 = 1; op0 = 7'h04;
        advance();
        advance();
        advance();
        chk("rst_pre_exec_e4", 64'(oe_4), 64'(1));
        #2 rst = 0;
        #1;
        chk("rst_async_e1", 64'(dut_outs(0)), 64'(0));
        chk("rst_async_e4", 64'(dut_outs(1)), 64'(0));
        m_reset();
        @(negedge clk);
        chk("rst_no_ack", 64'({ack0_1, ack1_1, ack0_4, ack1_4}), 64'(0));
        rst = 1;
        advance();
        chk("rst_restart_load", 64'({wa_1, wa_4, busy_1, busy_4}), 64'(4'hf));
        wait_idle();

        // Random traffic against the model, including illegal opcodes and mid-op input changes.
        for (int c = 0; c < 2000; c++) begin
            req0 = ($urandom_range(9) < 6);
            req1 = ($urandom_range(9) < 6);
            op0 = ($urandom_range(7) == 0) ? 7'($urandom) : 7'(1 << $urandom_range(6));
            op1 = ($urandom_range(7) == 0) ? 7'($urandom) : 7'(1 << $urandom_range(6));
            a0 = 8'($urandom); b0 = 8'($urandom); fi0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); fi1 = 8'($urandom);
            alu_d = 8'($urandom); alu_fo = 8'($urandom);
            advance();
        end
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
